// File: rtl/pipelined_ram_pkg.sv
// Shared defaults and width helpers for the pipelined RAM and anything that
// instantiates it, so the design and its users agree on sizes.
package pipelined_ram_pkg;

  localparam int DEFAULT_DATA_WIDTH_BYTES = 4;
  localparam int DEFAULT_NUM_SLOTS        = 5;
  localparam int DEFAULT_FORWARD          = 1;
  localparam int DEFAULT_INIT_VALUE       = 0;

  function automatic int data_bits(input int bytes);
    return bytes * 8;
  endfunction

  // A single-slot memory still needs a one-bit address port.
  function automatic int addr_bits(input int slots);
    return (slots < 2) ? 1 : $clog2(slots);
  endfunction

endpackage

// File: rtl/ram_byte_merge.sv
// Byte-strobe merge: each strobed byte comes from new_word, every other byte
// keeps its value from old_word.
module ram_byte_merge
  import pipelined_ram_pkg::*;
#(
  parameter int BYTES = DEFAULT_DATA_WIDTH_BYTES
) (
  input  logic [data_bits(BYTES)-1:0] old_word,
  input  logic [data_bits(BYTES)-1:0] new_word,
  input  logic [BYTES-1:0]            strb,
  output logic [data_bits(BYTES)-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int b = 0; b < BYTES; b++) begin
      if (strb[b]) begin
        merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/pipelined_ram.sv
// Register-based RAM with byte-strobed writes and a one-deep registered read
// response; out-of-range accesses are flagged rather than aliased.
module pipelined_ram
  import pipelined_ram_pkg::*;
#(
  parameter int DATA_WIDTH_BYTES = DEFAULT_DATA_WIDTH_BYTES,
  parameter int NUM_SLOTS        = DEFAULT_NUM_SLOTS,
  parameter int FORWARD          = DEFAULT_FORWARD,
  parameter logic [DATA_WIDTH_BYTES*8-1:0] INIT_VALUE =
    (DATA_WIDTH_BYTES*8)'(DEFAULT_INIT_VALUE)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 w_en,
  input  logic [addr_bits(NUM_SLOTS)-1:0]      w_addr,
  input  logic [data_bits(DATA_WIDTH_BYTES)-1:0] w_data,
  input  logic [DATA_WIDTH_BYTES-1:0]          w_strb,
  output logic                                 w_err,
  input  logic                                 r_req_valid,
  input  logic [addr_bits(NUM_SLOTS)-1:0]      r_addr,
  output logic                                 r_req_ready,
  output logic                                 r_resp_valid,
  output logic [data_bits(DATA_WIDTH_BYTES)-1:0] r_data,
  output logic                                 r_err,
  input  logic                                 r_resp_ready
);

  localparam int DW = data_bits(DATA_WIDTH_BYTES);
  localparam int AW = addr_bits(NUM_SLOTS);
  localparam logic [AW:0] SLOTS = (AW+1)'(NUM_SLOTS);

  logic [DW-1:0] mem [NUM_SLOTS];

  logic          w_in_range;
  logic          r_in_range;
  logic          w_fire;
  logic          r_fire;
  logic          fwd_hit;
  logic [DW-1:0] w_old;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] merged;
  logic [DW-1:0] r_next;

  assign w_in_range = ({1'b0, w_addr} < SLOTS);
  assign r_in_range = ({1'b0, r_addr} < SLOTS);

  // A clear swallows any same-cycle write, including its range error.
  assign w_fire = w_en && w_in_range && !clr;

  // Handshake: a request transfers on a rising edge where r_req_valid and
  // r_req_ready are both high; a response transfers where r_resp_valid and
  // r_resp_ready are both high. r_req_ready depends only on the response
  // register and r_resp_ready, never on r_req_valid, and a presented
  // response stays frozen until it transfers.
  assign r_req_ready = !r_resp_valid || r_resp_ready;
  assign r_fire      = r_req_valid && r_req_ready;

  assign fwd_hit = (FORWARD != 0) && w_fire && (w_addr == r_addr);

  // Slot selection by comparison keeps indexing safe for non-power-of-2 depths.
  always_comb begin
    w_old   = '0;
    rd_word = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_addr == AW'(i)) begin
        w_old = mem[i];
      end
      if (r_addr == AW'(i)) begin
        rd_word = mem[i];
      end
    end
  end

  // One merge serves both the stored write and the forwarded read data.
  ram_byte_merge #(
    .BYTES (DATA_WIDTH_BYTES)
  ) u_merge (
    .old_word (w_old),
    .new_word (w_data),
    .strb     (w_strb),
    .merged   (merged)
  );

  always_comb begin
    r_next = '0;
    if (r_in_range) begin
      r_next = fwd_hit ? merged : rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        mem[i] <= INIT_VALUE;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (clr) begin
          mem[i] <= INIT_VALUE;
        end else if (w_fire && (w_addr == AW'(i))) begin
          mem[i] <= merged;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_err <= 1'b0;
    end else begin
      w_err <= w_en && !w_in_range && !clr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_valid <= 1'b0;
      r_data       <= '0;
      r_err        <= 1'b0;
    end else if (r_fire) begin
      r_resp_valid <= 1'b1;
      r_data       <= r_next;
      r_err        <= !r_in_range;
    end else if (r_resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_ram.sv
// Directed bench for pipelined_ram: a forwarding and a non-forwarding instance
// share stimulus; responses are checked against hand-computed expected queues.
module tb_pipelined_ram;
  import pipelined_ram_pkg::*;

  localparam int DW = data_bits(DEFAULT_DATA_WIDTH_BYTES);
  localparam int AW = addr_bits(DEFAULT_NUM_SLOTS);
  localparam int NB = DEFAULT_DATA_WIDTH_BYTES;
  localparam int W  = DW + 1;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [NB-1:0] w_strb;
  logic          r_req_valid;
  logic [AW-1:0] r_addr;
  logic          r_resp_ready;

  logic          w_err, r_req_ready, r_resp_valid, r_err;
  logic [DW-1:0] r_data;
  logic          w_err_nf, r_req_ready_nf, r_resp_valid_nf, r_err_nf;
  logic [DW-1:0] r_data_nf;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_nf_q[$];
  int checks   = 0;
  int failures = 0;

  pipelined_ram #(.FORWARD(1)) dut (
    .clk (clk), .rst (rst), .clr (clr),
    .w_en (w_en), .w_addr (w_addr), .w_data (w_data), .w_strb (w_strb),
    .w_err (w_err),
    .r_req_valid (r_req_valid), .r_addr (r_addr), .r_req_ready (r_req_ready),
    .r_resp_valid (r_resp_valid), .r_data (r_data), .r_err (r_err),
    .r_resp_ready (r_resp_ready)
  );

  pipelined_ram #(.FORWARD(0)) dut_nf (
    .clk (clk), .rst (rst), .clr (clr),
    .w_en (w_en), .w_addr (w_addr), .w_data (w_data), .w_strb (w_strb),
    .w_err (w_err_nf),
    .r_req_valid (r_req_valid), .r_addr (r_addr), .r_req_ready (r_req_ready_nf),
    .r_resp_valid (r_resp_valid_nf), .r_data (r_data_nf), .r_err (r_err_nf),
    .r_resp_ready (r_resp_ready)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rsp(input logic e, input logic [DW-1:0] d);
    return {e, d};
  endfunction

  // Monitor: pop and compare on every response handshake
  always @(negedge clk) begin
    if (r_resp_valid && r_resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected actual=%h expected=none", {r_err, r_data});
      end else begin
        check("resp_fwd", {r_err, r_data}, exp_q.pop_front());
      end
    end
    if (r_resp_valid_nf && r_resp_ready) begin
      if (exp_nf_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_nf_unexpected actual=%h expected=none", {r_err_nf, r_data_nf});
      end else begin
        check("resp_nofwd", {r_err_nf, r_data_nf}, exp_nf_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    w_en   = 1'b1;
    w_addr = a;
    w_data = d;
    w_strb = s;
    tick();
    w_en   = 1'b0;
    w_strb = '0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [W-1:0] e_fwd, input logic [W-1:0] e_nf);
    int n;
    n = 0;
    r_req_valid = 1'b1;
    r_addr      = a;
    exp_q.push_back(e_fwd);
    exp_nf_q.push_back(e_nf);
    @(negedge clk);
    while (!r_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!r_req_ready) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout actual=0 expected=1");
    end
    tick();
    r_req_valid = 1'b0;
    check("read_latency", {63'd0, r_resp_valid}, 64'd1);
  endtask

  task automatic read_all(input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                          input logic [DW-1:0] e3, input logic [DW-1:0] e4);
    logic [DW-1:0] e [5];
    e = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < 5; i++) begin
      do_read(AW'(i), rsp(1'b0, e[i]), rsp(1'b0, e[i]));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_nf_q.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    check("drain_fwd", 64'(exp_q.size()), 64'd0);
    check("drain_nofwd", 64'(exp_nf_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0; w_strb = '0;
    r_req_valid = 1'b0; r_addr = '0; r_resp_ready = 1'b1;

    // Reset state
    #2;
    check("rst_resp_valid", {63'd0, r_resp_valid}, 64'd0);
    check("rst_r_data", 64'(r_data), 64'd0);
    check("rst_r_err", {63'd0, r_err}, 64'd0);
    check("rst_w_err", {63'd0, w_err}, 64'd0);
    check("rst_req_ready", {63'd0, r_req_ready}, 64'd1);
    check("rst_req_ready_nf", {63'd0, r_req_ready_nf}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    read_all(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Strobed write, bytes 0,2,3
    do_write(3'd0, 32'h11223344, 4'b1101);
    do_read(3'd0, rsp(1'b0, 32'h11220044), rsp(1'b0, 32'h11220044));

    // Zero strobe is a no-op
    do_write(3'd1, 32'hFFFFFFFF, 4'b0000);
    do_read(3'd1, rsp(1'b0, 32'h0), rsp(1'b0, 32'h0));

    // Same-cycle write and read of addr 2
    do_write(3'd2, 32'hAABBCCDD, 4'b1111);
    w_en = 1'b1; w_addr = 3'd2; w_data = 32'h00003300; w_strb = 4'b0010;
    do_read(3'd2, rsp(1'b0, 32'hAABB33DD), rsp(1'b0, 32'hAABBCCDD));
    w_en = 1'b0; w_strb = '0;
    do_read(3'd2, rsp(1'b0, 32'hAABB33DD), rsp(1'b0, 32'hAABB33DD));

    // Out-of-range write and read
    do_write(3'd6, 32'hFFFFFFFF, 4'b1111);
    check("oor_w_err_pulse", {63'd0, w_err}, 64'd1);
    check("oor_w_err_pulse_nf", {63'd0, w_err_nf}, 64'd1);
    tick();
    check("oor_w_err_drop", {63'd0, w_err}, 64'd0);
    do_read(3'd7, rsp(1'b1, 32'h0), rsp(1'b1, 32'h0));
    read_all(32'h11220044, 32'h0, 32'hAABB33DD, 32'h0, 32'h0);
    wait_drain();

    // Back-to-back reads with a 3-cycle response stall
    fork
      begin
        do_read(3'd0, rsp(1'b0, 32'h11220044), rsp(1'b0, 32'h11220044));
        do_read(3'd1, rsp(1'b0, 32'h0), rsp(1'b0, 32'h0));
        do_read(3'd2, rsp(1'b0, 32'hAABB33DD), rsp(1'b0, 32'hAABB33DD));
      end
      begin
        int n;
        n = 0;
        tick();
        while (!r_resp_valid && n < 20) begin
          tick();
          n++;
        end
        r_resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_req_ready", {63'd0, r_req_ready}, 64'd0);
          check("stall_resp_valid", {63'd0, r_resp_valid}, 64'd1);
          check("stall_hold_data", {31'd0, r_err, r_data}, {31'd0, rsp(1'b0, 32'h11220044)});
        end
        tick();
        r_resp_ready = 1'b1;
      end
    join
    wait_drain();

    // Clear with same-cycle write and read
    clr = 1'b1; w_en = 1'b1; w_addr = 3'd1; w_data = 32'h12345678; w_strb = 4'b1111;
    do_read(3'd0, rsp(1'b0, 32'h11220044), rsp(1'b0, 32'h11220044));
    clr = 1'b0; w_en = 1'b0; w_strb = '0;
    check("clr_no_w_err", {63'd0, w_err}, 64'd0);
    read_all(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    wait_drain();

    // Asynchronous reset with a pending response
    do_write(3'd3, 32'hDEADBEEF, 4'b1111);
    r_resp_ready = 1'b0;
    do_read(3'd3, rsp(1'b0, 32'hDEADBEEF), rsp(1'b0, 32'hDEADBEEF));
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, r_resp_valid}, 64'd0);
    check("async_rst_valid_nf", {63'd0, r_resp_valid_nf}, 64'd0);
    check("async_rst_data", 64'(r_data), 64'd0);
    exp_q.delete();
    exp_nf_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    r_resp_ready = 1'b1;
    read_all(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_ram.md
PIPELINED_RAM -- requirements
Module: pipelined_ram

Interface
REQ-001 Parameter DATA_WIDTH_BYTES, default 4: word width in bytes; the data width in bits SHALL be DATA_WIDTH_BYTES*8.
REQ-002 Parameter NUM_SLOTS, default 5: number of words; any value >= 2 (non-power-of-2 legal); ADDR_WIDTH_BITS SHALL be $clog2(NUM_SLOTS).
REQ-003 Parameter FORWARD, default 1: 1 = same-cycle write-to-read forwarding, 0 = read returns pre-write data.
REQ-004 Parameter INIT_VALUE, default 0: reset/clear value of every word.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 clr  in  1  synchronous clear of all words to INIT_VALUE.
REQ-008 w_en, w_addr, w_data, w_strb  in  1 / ADDR_WIDTH_BITS / DATA bits / DATA_WIDTH_BYTES  write command, strb bit i enables byte i.
REQ-009 w_err  out  1  one-cycle pulse flagging an out-of-range write.
REQ-010 r_req_valid, r_addr  in  1 / ADDR_WIDTH_BITS  read request; r_req_ready  out  1.
REQ-011 r_resp_valid, r_data, r_err  out  1 / DATA bits / 1  read response; r_resp_ready  in  1.

Function
REQ-012 A write with w_en=1 and w_addr<NUM_SLOTS SHALL update only the strobed bytes of memory[w_addr] at the clock edge; w_strb=0 is a legal no-op.
REQ-013 A write with w_addr>=NUM_SLOTS SHALL leave memory unchanged and assert w_err for exactly the next cycle.
REQ-014 Read handshake: a request is accepted when r_req_valid && r_req_ready; r_req_ready SHALL equal !r_resp_valid || r_resp_ready (single response register, no combinational path from r_req_valid).
REQ-015 Read latency SHALL be 1 cycle: an accepted request presents r_resp_valid=1 with r_data on the following cycle.
REQ-016 The response SHALL hold r_data, r_err, r_resp_valid stable while r_resp_valid && !r_resp_ready.
REQ-017 r_resp_valid SHALL drop after the response handshake unless a new request is accepted on the same edge (back-to-back reads give one response per cycle).
REQ-018 Out-of-range read: r_err=1 and r_data=0 in the response; memory unaffected.
REQ-019 Accepted read and write to the same in-range address in one cycle: FORWARD=1 returns the merged word (strobed bytes new, others old); FORWARD=0 returns the pre-write word.
REQ-020 clr=1 SHALL set every word to INIT_VALUE and discard any same-cycle write (no w_err); a read accepted in the same cycle returns the pre-clear word; a pending response is not affected.
REQ-021 Priority per word: clr > write > hold.

Reset
REQ-022 While rst=0: every word = INIT_VALUE, r_resp_valid=0, r_data=0, r_err=0, w_err=0, r_req_ready=1.
REQ-023 Reset asserted mid-operation SHALL discard any pending response immediately (asynchronous); first request after release is accepted normally.

Structure
REQ-024 A shared package SHALL hold the width helper functions and the default parameter values used by both RTL and bench.
REQ-025 One sub-module, ram_byte_merge, SHALL compute the strobe-merged word (used by both write path and forwarding path).

Verification (NUM_SLOTS=5, DATA_WIDTH_BYTES=4, FORWARD=1, INIT_VALUE=0)
REQ-026 Write addr 0 data 0x11223344 strb 0b1101, then read addr 0 -> r_data 0x11220044, r_err 0, one cycle after acceptance.
REQ-027 Same cycle: write addr 2 data 0x00003300 strb 0b0010 over stored 0xAABBCCDD and read addr 2 -> r_data 0xAABB33DD; repeat with FORWARD=0 -> 0xAABBCCDD.
REQ-028 Write addr 6 data 0xFFFFFFFF strb 0b1111 -> w_err pulses 1 cycle, all words unchanged; read addr 7 -> r_err 1, r_data 0.
REQ-029 Back-to-back reads of addr 0,1,2 with r_resp_ready held 0 for 3 cycles after first response -> r_req_ready 0 during stall, responses delivered in order without loss or duplication.
REQ-030 clr=1 with same-cycle write to addr 1 -> all five words read back 0, no w_err.
REQ-031 Assert rst low while r_resp_valid=1 -> r_resp_valid 0 asynchronously, all words 0 after release.
